shop_cmd_framer: RTL and testbench
==================================

Name: shop_cmd_framer

Overview:
- Upstream stage of the shop command unit.
- Receives a byte-serial ASCII command stream, one character per strobe, and parses lines of the form "<user-id> <cmd>\n".
- Drives the shop input triplet (rdy strobe, user id, right-justified ASCII command word) with the same packing a Verilog string literal gives.
- Flags malformed lines and resynchronises at the next newline.

Parameters:
- I_A_NUM_ASCII_CHARS, 7, max command characters; must fit the longest command key.
- I_A_NUM_BITS, I_A_NUM_ASCII_CHARS*8, command word width.
- I_U_NUM_BITS, 4, user id width; max id is 2**I_U_NUM_BITS-1.
- MAX_ID_DIGITS, 2, max decimal digits accepted in the user-id field.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_byte_vld  in  1  one-cycle strobe: i_byte holds a new character.
- i_byte  in  8  ASCII character.
- o_rdy  out  1  one-cycle pulse: o_u/o_a hold a complete command.
- o_u  out  I_U_NUM_BITS  parsed user id.
- o_a  out  I_A_NUM_BITS  command text, right-justified, upper bytes zero.
- o_err  out  1  one-cycle pulse: current line rejected.
- o_busy  out  1  high while a line is partially received (not in S_IDLE).

Behaviour:
- Reset (i_reset=0, async): state S_IDLE; o_rdy=0, o_err=0, o_u=0, o_a=0, digit counter 0, char counter 0.
- All state changes occur only on cycles with i_byte_vld=1, except the EMIT/ERR pulses.
- S_IDLE:
  - '0'-'9': acc=digit, ndig=1, go S_USER.
  - ' ' or '\n': ignore and stay.
  - Anything else: go S_SKIP.
- S_USER:
  - Digit: acc=acc*10+digit, ndig+1. If ndig would exceed MAX_ID_DIGITS, or acc exceeds 2**I_U_NUM_BITS-1: go S_SKIP.
  - ' ': clear cmd shift register and char count, go S_CMD.
  - '\n' or other: o_err pulse, go S_IDLE on '\n', else S_SKIP.
- S_CMD:
  - Printable 0x21-0x7E: cmd={cmd[I_A_NUM_BITS-9:0],byte}, nchar+1. If nchar would exceed I_A_NUM_ASCII_CHARS: go S_SKIP.
  - '\n' with nchar>=1: go S_EMIT.
  - '\n' with nchar=0: o_err pulse, go S_IDLE.
  - Any other byte: go S_SKIP.
- S_EMIT (one cycle, no byte needed): o_u<=acc, o_a<=cmd, o_rdy=1 for exactly this cycle, go S_IDLE.
  - A byte arriving during S_EMIT is processed as if in S_IDLE (no byte lost).
- S_SKIP:
  - o_err pulses once on entry.
  - Discard bytes until '\n', then go S_IDLE (the '\n' itself is consumed).
- Outputs:
  - o_u/o_a change only in S_EMIT and hold until the next emit; errors leave them unchanged.
  - Latency: o_rdy asserts the cycle after the '\n' strobe.
  - o_rdy and o_err are never high together.
- Width rules:
  - acc is I_U_NUM_BITS+4 bits wide, so the overflow compare is exact.
  - Command shorter than I_A_NUM_ASCII_CHARS leaves upper bytes zero.
- Reset mid-line: the partial line is dropped; the first byte after reset is parsed from S_IDLE.

Optional Feature:
- Macro SHOP_FRAMER_CMD_CHECK_EN.
- Defined: in S_EMIT, cmd is compared against the seven keys "Logout", "Login", "AddUsr", "DelUsr", "AddItem", "DelItem", "Buy" (right-justified).
  - Mismatch: o_err pulses instead of o_rdy, and o_u/o_a are not updated.
- Undefined: any 1..I_A_NUM_ASCII_CHARS printable string is emitted; validation is left to the shop unit.

Test Plan:
- Reset low 2 cycles, then stream "4 Login\n": one o_rdy pulse the cycle after '\n'; o_u=4, o_a=56'h00_00_4C_6F_67_69_6E; o_err never high.
- "15 AddItem\n" then "7 Buy\n", back-to-back strobes every cycle: two o_rdy pulses; o_u=15, o_a="AddItem", then o_u=7, o_a=56'h0000000042_7579.
- "16 Buy\n" and "123 Buy\n": one o_err pulse each, no o_rdy; o_u/o_a keep prior values; a following "3 Buy\n" emits o_u=3.
- "2 AddItemX\n" (8 chars) and "5 \n": o_err once per line, no o_rdy, next line parses normally.
- Assert reset mid-line after "9 Log", then send "1 Logout\n": no emit for the partial line; o_rdy with o_u=1, o_a="Logout".
- With SHOP_FRAMER_CMD_CHECK_EN: "3 hi\n" gives o_err, no o_rdy; "3 DelUsr\n" gives o_rdy. Without the macro: "3 hi\n" gives o_rdy with o_a=56'h6869.

Source files
------------

// File: rtl/shop_cmd_framer.sv
// -----------------------------------------------------------------------------
// shop_cmd_framer
//
// Upstream framer for the shop command unit. Consumes a byte-serial ASCII
// stream (one character per i_byte_vld strobe), parses lines of the form
// "<user-id> <cmd>\n" and presents each complete command as a one-cycle
// o_rdy pulse with the user id on o_u and the command text on o_a. The text
// is right-justified with zero upper bytes, which is the same packing a
// Verilog string literal gets. Malformed lines raise a one-cycle o_err pulse
// and the framer resynchronises at the next newline.
//
// Optional feature (macro SHOP_FRAMER_CMD_CHECK_EN):
//   when defined, only the seven shop command keys are emitted; any other
//   command text produces o_err instead of o_rdy and leaves o_u/o_a alone.
//
// Ports:
//   i_clk       in   1             system clock, rising edge
//   i_reset     in   1             asynchronous active-low reset
//   i_byte_vld  in   1             strobe: i_byte holds a new character
//   i_byte      in   8             ASCII character
//   o_rdy       out  1             pulse: o_u/o_a hold a complete command
//   o_u         out  I_U_NUM_BITS  parsed user id
//   o_a         out  I_A_NUM_BITS  command text, right-justified
//   o_err       out  1             pulse: current line rejected
//   o_busy      out  1             high while a line is partially received
// -----------------------------------------------------------------------------
module shop_cmd_framer #(
  parameter int I_A_NUM_ASCII_CHARS = 7,
  parameter int I_A_NUM_BITS        = I_A_NUM_ASCII_CHARS * 8,
  parameter int I_U_NUM_BITS        = 4,
  parameter int MAX_ID_DIGITS       = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_byte_vld,
  input  logic [7:0]              i_byte,
  output logic                    o_rdy,
  output logic [I_U_NUM_BITS-1:0] o_u,
  output logic [I_A_NUM_BITS-1:0] o_a,
  output logic                    o_err,
  output logic                    o_busy
);

  // Four spare bits on the accumulator so acc*10+9 never wraps before the
  // range compare against the largest legal id.
  localparam int ACC_W  = I_U_NUM_BITS + 4;
  localparam int NDIG_W = $clog2(MAX_ID_DIGITS + 1);
  localparam int NCHR_W = $clog2(I_A_NUM_ASCII_CHARS + 1);

  localparam logic [ACC_W-1:0]  MAX_ID  = ACC_W'((64'd1 << I_U_NUM_BITS) - 64'd1);
  localparam logic [NDIG_W-1:0] MAX_DIG = NDIG_W'(MAX_ID_DIGITS);
  localparam logic [NCHR_W-1:0] MAX_CHR = NCHR_W'(I_A_NUM_ASCII_CHARS);

  localparam logic [7:0] CH_NL = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_USER = 3'd1,
    S_CMD  = 3'd2,
    S_EMIT = 3'd3,
    S_SKIP = 3'd4
  } state_t;

`ifdef SHOP_FRAMER_CMD_CHECK_EN
  // True when the right-justified command text equals one of the shop keys.
  function automatic logic is_cmd_key(input logic [I_A_NUM_BITS-1:0] cmd);
    logic hit;
    hit = 1'b0;
    hit = hit | (cmd == I_A_NUM_BITS'(56'h00_4C6F676F7574));  // "Logout"
    hit = hit | (cmd == I_A_NUM_BITS'(56'h0000_4C6F67696E));  // "Login"
    hit = hit | (cmd == I_A_NUM_BITS'(56'h00_416464557372));  // "AddUsr"
    hit = hit | (cmd == I_A_NUM_BITS'(56'h00_44656C557372));  // "DelUsr"
    hit = hit | (cmd == I_A_NUM_BITS'(56'h4164644974656D));   // "AddItem"
    hit = hit | (cmd == I_A_NUM_BITS'(56'h44656C4974656D));   // "DelItem"
    hit = hit | (cmd == I_A_NUM_BITS'(56'h00000000427579));   // "Buy"
    return hit;
  endfunction
`endif

  state_t                  state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [NDIG_W-1:0]       ndig_q, ndig_d;
  logic [NCHR_W-1:0]       nchar_q, nchar_d;
  logic [I_A_NUM_BITS-1:0] cmd_q, cmd_d;
  logic [I_U_NUM_BITS-1:0] u_q, u_d;
  logic [I_A_NUM_BITS-1:0] a_q, a_d;
  logic                    rdy_q, rdy_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;

  logic                    is_digit_s;
  logic                    is_print_s;
  logic [3:0]              digit_s;
  logic [ACC_W-1:0]        acc_next_s;
  logic                    key_ok_s;

  assign is_digit_s = (i_byte >= 8'h30) && (i_byte <= 8'h39);
  assign is_print_s = (i_byte >= 8'h21) && (i_byte <= 8'h7E);
  // For '0'..'9' the low nibble is the digit value.
  assign digit_s    = i_byte[3:0];
  assign acc_next_s = (acc_q * ACC_W'(4'd10)) + ACC_W'(digit_s);

`ifdef SHOP_FRAMER_CMD_CHECK_EN
  assign key_ok_s = is_cmd_key(cmd_q);
`else
  assign key_ok_s = 1'b1;
`endif

  // Next-state and pulse decode for the line parser.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ndig_d  = ndig_q;
    nchar_d = nchar_q;
    cmd_d   = cmd_q;
    u_d     = u_q;
    a_d     = a_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      // S_EMIT lasts one cycle; a byte landing in it is parsed as in S_IDLE.
      S_IDLE, S_EMIT: begin
        state_d = S_IDLE;
        if (i_byte_vld) begin
          if (is_digit_s) begin
            acc_d   = ACC_W'(digit_s);
            ndig_d  = NDIG_W'(1'b1);
            state_d = S_USER;
          end else if ((i_byte == CH_SP) || (i_byte == CH_NL)) begin
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_SKIP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_USER: begin
        if (i_byte_vld) begin
          if (is_digit_s) begin
            if ((ndig_q >= MAX_DIG) || (acc_next_s > MAX_ID)) begin
              err_d   = 1'b1;
              state_d = S_SKIP;
            end else begin
              acc_d  = acc_next_s;
              ndig_d = ndig_q + NDIG_W'(1'b1);
            end
          end else if (i_byte == CH_SP) begin
            cmd_d   = '0;
            nchar_d = '0;
            state_d = S_CMD;
          end else if (i_byte == CH_NL) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_SKIP;
          end
        end else begin
          state_d = S_USER;
        end
      end

      S_CMD: begin
        if (i_byte_vld) begin
          if (is_print_s) begin
            if (nchar_q >= MAX_CHR) begin
              err_d   = 1'b1;
              state_d = S_SKIP;
            end else begin
              cmd_d   = {cmd_q[I_A_NUM_BITS-9:0], i_byte};
              nchar_d = nchar_q + NCHR_W'(1'b1);
            end
          end else if (i_byte == CH_NL) begin
            if (nchar_q != '0) begin
              // Output registers load on the same edge that enters S_EMIT,
              // so o_u/o_a are valid for the whole o_rdy cycle.
              state_d = S_EMIT;
              if (key_ok_s) begin
                rdy_d = 1'b1;
                u_d   = acc_q[I_U_NUM_BITS-1:0];
                a_d   = cmd_q;
              end else begin
                err_d = 1'b1;
              end
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            err_d   = 1'b1;
            state_d = S_SKIP;
          end
        end else begin
          state_d = S_CMD;
        end
      end

      // The error was flagged on entry; just swallow bytes through '\n'.
      S_SKIP: begin
        if (i_byte_vld && (i_byte == CH_NL)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SKIP;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Parser state and registered outputs; async clear on active-low reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ndig_q  <= '0;
      nchar_q <= '0;
      cmd_q   <= '0;
      u_q     <= '0;
      a_q     <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ndig_q  <= ndig_d;
      nchar_q <= nchar_d;
      cmd_q   <= cmd_d;
      u_q     <= u_d;
      a_q     <= a_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign o_rdy  = rdy_q;
  assign o_err  = err_q;
  assign o_u    = u_q;
  assign o_a    = a_q;
  assign o_busy = busy_q;

endmodule

// File: tb/tb_shop_cmd_framer.sv
// -----------------------------------------------------------------------------
// tb_shop_cmd_framer
//
// Self-checking bench for shop_cmd_framer. Directed scenarios from the test
// plan plus randomized lines checked against a line-level reference model
// (parse the whole line as text, decide emit/error/nothing).
// -----------------------------------------------------------------------------
module tb_shop_cmd_framer;

  localparam int NCH = 7;
  localparam int AW  = NCH * 8;
  localparam int UW  = 4;
  localparam int MD  = 2;

  typedef logic [UW+AW-1:0] evt_t;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_byte_vld = 1'b0;
  logic [7:0]    i_byte = 8'h00;
  logic          o_rdy;
  logic          o_err;
  logic          o_busy;
  logic [UW-1:0] o_u;
  logic [AW-1:0] o_a;

  int checks = 0;
  int failures = 0;

  // Pulse monitor
  evt_t rdy_evt[$];
  int   err_cnt = 0;
  int   both_cnt = 0;

  // Last emitted command as predicted by the model
  logic [UW-1:0] exp_u = '0;
  logic [AW-1:0] exp_a = '0;

  string keys[7] = '{"Logout", "Login", "AddUsr", "DelUsr", "AddItem", "DelItem", "Buy"};

  shop_cmd_framer #(
    .I_A_NUM_ASCII_CHARS(NCH),
    .I_A_NUM_BITS(AW),
    .I_U_NUM_BITS(UW),
    .MAX_ID_DIGITS(MD)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_byte_vld(i_byte_vld),
    .i_byte(i_byte),
    .o_rdy(o_rdy),
    .o_u(o_u),
    .o_a(o_a),
    .o_err(o_err),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_rdy === 1'b1) rdy_evt.push_back({o_u, o_a});
    if (o_err === 1'b1) err_cnt++;
    if ((o_rdy === 1'b1) && (o_err === 1'b1)) both_cnt++;
  end

  // Reference model: classify one line (without its '\n') starting from idle.
  // Returns 0 = no event, 1 = command emitted (u/a valid), 2 = error.
  function automatic int model_line(input string s, output logic [UW-1:0] u,
                                    output logic [AW-1:0] a);
    int i;
    int n;
    int nd;
    int val;
    bit found;
    string cmd;
    i = 0; n = s.len(); nd = 0; val = 0;
    u = '0; a = '0;
    while (i < n && s[i] == 8'h20) i++;
    if (i == n) return 0;
    while (i < n && s[i] >= 8'h30 && s[i] <= 8'h39) begin
      val = val * 10 + int'(s[i] - 8'h30);
      nd++;
      i++;
    end
    if (nd == 0 || nd > MD || val > (1 << UW) - 1) return 2;
    if (i == n || s[i] != 8'h20) return 2;
    i++;
    if (n - i < 1 || n - i > NCH) return 2;
    for (int k = i; k < n; k++) begin
      if (s[k] < 8'h21 || s[k] > 8'h7E) return 2;
      a = (a << 8) | AW'(s[k]);
    end
    cmd = s.substr(i, n - 1);
    found = 1'b0;
    foreach (keys[k]) if (keys[k] == cmd) found = 1'b1;
`ifdef SHOP_FRAMER_CMD_CHECK_EN
    if (!found) return 2;
`endif
    u = UW'(val);
    return 1;
  endfunction

  function automatic string gen_line();
    int kind;
    int id;
    int len;
    string cmd;
    string s;
    kind = $urandom_range(0, 11);
    id   = $urandom_range(0, 15);
    cmd  = "";
    if ($urandom_range(0, 1) == 1) begin
      cmd = keys[$urandom_range(0, 6)];
    end else begin
      len = $urandom_range(1, NCH);
      for (int k = 0; k < len; k++) cmd = $sformatf("%s%c", cmd, 8'($urandom_range(33, 126)));
    end
    case (kind)
      0: s = $sformatf("%0d %s", $urandom_range(16, 99), cmd);
      1: s = $sformatf("%0d %s", $urandom_range(100, 999), cmd);
      2: s = $sformatf("%0d %sZZ", id, cmd);
      3: s = $sformatf("%0d %s x", id, cmd);
      4: s = $sformatf("%0d ", id);
      5: s = $sformatf("%0d", id);
      6: s = $sformatf("#%0d %s", id, cmd);
      7: s = $sformatf("%02d %s", id, cmd);
      8: s = $sformatf("%0dq %s", id, cmd);
      default: s = $sformatf("%0d %s", id, cmd);
    endcase
    return s;
  endfunction

  task automatic send_line(input string s, input int gap_max);
    for (int k = 0; k < s.len(); k++) begin
      if (gap_max > 0) begin
        int g;
        g = $urandom_range(0, gap_max);
        repeat (g) begin
          @(negedge i_clk);
          i_byte_vld = 1'b0;
        end
      end
      @(negedge i_clk);
      i_byte     = s[k];
      i_byte_vld = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge i_clk);
      i_byte_vld = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1 i_reset = 1'b0;
    repeat (2) @(negedge i_clk);
    checks++; if (o_rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", o_rdy); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", o_err); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if (o_u !== '0) begin failures++; $display("FAIL reset_u got=%h exp=0", o_u); end
    checks++; if (o_a !== '0) begin failures++; $display("FAIL reset_a got=%h exp=0", o_a); end
    i_reset = 1'b1;
    idle(2);
    rdy_evt.delete(); err_cnt = 0;
  endtask

  task automatic test_login();
    send_line("4 Login", 0);
    @(negedge i_clk);
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL login_busy got=%b exp=1", o_busy); end
    i_byte = 8'h0A; i_byte_vld = 1'b1;
    @(negedge i_clk);
    i_byte_vld = 1'b0;
    checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL login_latency got=%b exp=1", o_rdy); end
    checks++; if (o_u !== 4'd4) begin failures++; $display("FAIL login_u got=%h exp=4", o_u); end
    checks++; if (o_a !== 56'h00_00_4C_6F_67_69_6E) begin failures++; $display("FAIL login_a got=%h exp=00004c6f67696e", o_a); end
    @(negedge i_clk);
    checks++; if (o_rdy !== 1'b0) begin failures++; $display("FAIL login_pulse_width got=%b exp=0", o_rdy); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL login_busy_end got=%b exp=0", o_busy); end
    idle(2);
    checks++; if (err_cnt !== 0) begin failures++; $display("FAIL login_err got=%0d exp=0", err_cnt); end
    checks++; if (rdy_evt.size() !== 1) begin failures++; $display("FAIL login_rdy_count got=%0d exp=1", rdy_evt.size()); end
    exp_u = 4'd4; exp_a = 56'h00_00_4C_6F_67_69_6E;
    rdy_evt.delete(); err_cnt = 0;
  endtask

  task automatic test_back_to_back();
    send_line("15 AddItem\n7 Buy\n", 0);
    idle(3);
    checks++; if (rdy_evt.size() !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", rdy_evt.size()); end
    if (rdy_evt.size() == 2) begin
      checks++; if (rdy_evt[0] !== {4'd15, 56'h41_64_64_49_74_65_6D}) begin failures++; $display("FAIL b2b_first got=%h exp=f4164644974656d", rdy_evt[0]); end
      checks++; if (rdy_evt[1] !== {4'd7, 56'h00000000_427579}) begin failures++; $display("FAIL b2b_second got=%h exp=700000000427579", rdy_evt[1]); end
    end
    checks++; if (err_cnt !== 0) begin failures++; $display("FAIL b2b_err got=%0d exp=0", err_cnt); end
    exp_u = 4'd7; exp_a = 56'h00000000_427579;
    rdy_evt.delete(); err_cnt = 0;
  endtask

  task automatic test_bad_id();
    send_line("16 Buy\n123 Buy\n", 1);
    idle(3);
    checks++; if (err_cnt !== 2) begin failures++; $display("FAIL badid_err got=%0d exp=2", err_cnt); end
    checks++; if (rdy_evt.size() !== 0) begin failures++; $display("FAIL badid_rdy got=%0d exp=0", rdy_evt.size()); end
    checks++; if (o_u !== exp_u) begin failures++; $display("FAIL badid_hold_u got=%h exp=%h", o_u, exp_u); end
    checks++; if (o_a !== exp_a) begin failures++; $display("FAIL badid_hold_a got=%h exp=%h", o_a, exp_a); end
    rdy_evt.delete(); err_cnt = 0;
    send_line("3 Buy\n", 0);
    idle(3);
    checks++; if (rdy_evt.size() !== 1) begin failures++; $display("FAIL badid_recover got=%0d exp=1", rdy_evt.size()); end
    checks++; if (o_u !== 4'd3) begin failures++; $display("FAIL badid_recover_u got=%h exp=3", o_u); end
    exp_u = 4'd3; exp_a = 56'h00000000_427579;
    rdy_evt.delete(); err_cnt = 0;
  endtask

  task automatic test_bad_cmd();
    send_line("2 AddItemX\n5 \n", 0);
    idle(3);
    checks++; if (err_cnt !== 2) begin failures++; $display("FAIL badcmd_err got=%0d exp=2", err_cnt); end
    checks++; if (rdy_evt.size() !== 0) begin failures++; $display("FAIL badcmd_rdy got=%0d exp=0", rdy_evt.size()); end
    checks++; if (o_a !== exp_a) begin failures++; $display("FAIL badcmd_hold_a got=%h exp=%h", o_a, exp_a); end
    rdy_evt.delete(); err_cnt = 0;
    send_line("6 Login\n", 0);
    idle(3);
    checks++; if (rdy_evt.size() !== 1) begin failures++; $display("FAIL badcmd_recover got=%0d exp=1", rdy_evt.size()); end
    checks++; if ({o_u, o_a} !== {4'd6, 56'h0000_4C6F67696E}) begin failures++; $display("FAIL badcmd_recover_val got=%h exp=600004c6f67696e", {o_u, o_a}); end
    exp_u = 4'd6; exp_a = 56'h0000_4C6F67696E;
    rdy_evt.delete(); err_cnt = 0;
  endtask

  task automatic test_reset_midline();
    send_line("9 Log", 0);
    @(negedge i_clk);
    i_byte_vld = 1'b0;
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", o_busy); end
    checks++; if (o_u !== '0) begin failures++; $display("FAIL midrst_u got=%h exp=0", o_u); end
    i_reset = 1'b1;
    rdy_evt.delete(); err_cnt = 0;
    send_line("1 Logout\n", 0);
    idle(3);
    checks++; if (rdy_evt.size() !== 1) begin failures++; $display("FAIL midrst_count got=%0d exp=1", rdy_evt.size()); end
    checks++; if ({o_u, o_a} !== {4'd1, 56'h00_4C6F676F7574}) begin failures++; $display("FAIL midrst_val got=%h exp=1004c6f676f7574", {o_u, o_a}); end
    checks++; if (err_cnt !== 0) begin failures++; $display("FAIL midrst_err got=%0d exp=0", err_cnt); end
    exp_u = 4'd1; exp_a = 56'h00_4C6F676F7574;
    rdy_evt.delete(); err_cnt = 0;
  endtask

  task automatic test_cmd_check();
    send_line("3 hi\n", 0);
    idle(3);
`ifdef SHOP_FRAMER_CMD_CHECK_EN
    checks++; if (err_cnt !== 1) begin failures++; $display("FAIL chk_hi_err got=%0d exp=1", err_cnt); end
    checks++; if (rdy_evt.size() !== 0) begin failures++; $display("FAIL chk_hi_rdy got=%0d exp=0", rdy_evt.size()); end
    checks++; if (o_a !== exp_a) begin failures++; $display("FAIL chk_hi_hold got=%h exp=%h", o_a, exp_a); end
`else
    checks++; if (err_cnt !== 0) begin failures++; $display("FAIL chk_hi_err got=%0d exp=0", err_cnt); end
    checks++; if (rdy_evt.size() !== 1) begin failures++; $display("FAIL chk_hi_rdy got=%0d exp=1", rdy_evt.size()); end
    checks++; if (o_a !== 56'h00000000006869) begin failures++; $display("FAIL chk_hi_a got=%h exp=6869", o_a); end
    exp_u = 4'd3; exp_a = 56'h00000000006869;
`endif
    rdy_evt.delete(); err_cnt = 0;
    send_line("3 DelUsr\n", 0);
    idle(3);
    checks++; if (rdy_evt.size() !== 1) begin failures++; $display("FAIL chk_delusr_rdy got=%0d exp=1", rdy_evt.size()); end
    checks++; if (o_a !== 56'h00_44656C557372) begin failures++; $display("FAIL chk_delusr_a got=%h exp=0044656c557372", o_a); end
    exp_u = 4'd3; exp_a = 56'h00_44656C557372;
    rdy_evt.delete(); err_cnt = 0;
  endtask

  task automatic test_random(input int nlines);
    for (int n = 0; n < nlines; n++) begin
      string s;
      int kind;
      logic [UW-1:0] mu;
      logic [AW-1:0] ma;
      s = gen_line();
      kind = model_line(s, mu, ma);
      rdy_evt.delete(); err_cnt = 0;
      send_line({s, "\n"}, $urandom_range(0, 2));
      idle(3);
      if (kind == 1) begin
        exp_u = mu;
        exp_a = ma;
      end
      checks++; if (rdy_evt.size() !== ((kind == 1) ? 1 : 0)) begin failures++; $display("FAIL rand_rdy line=\"%s\" got=%0d exp=%0d", s, rdy_evt.size(), (kind == 1) ? 1 : 0); end
      checks++; if (err_cnt !== ((kind == 2) ? 1 : 0)) begin failures++; $display("FAIL rand_err line=\"%s\" got=%0d exp=%0d", s, err_cnt, (kind == 2) ? 1 : 0); end
      checks++; if ({o_u, o_a} !== {exp_u, exp_a}) begin failures++; $display("FAIL rand_out line=\"%s\" got=%h exp=%h", s, {o_u, o_a}, {exp_u, exp_a}); end
    end
    rdy_evt.delete(); err_cnt = 0;
  endtask

  task automatic test_no_overlap();
    checks++; if (both_cnt !== 0) begin failures++; $display("FAIL rdy_err_overlap got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_login();
    test_back_to_back();
    test_bad_id();
    test_bad_cmd();
    test_reset_midline();
    test_cmd_check();
    test_random(80);
    test_no_overlap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
